// File: rtl/axi_lite_master_arbiter_if.sv
// rtl/axi_lite_master_arbiter_if.sv - upstream per-master and downstream AXI4-Lite bus bundle for the master arbiter
interface axi_lite_master_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_awaddr;
    logic [NUM_MASTERS*3-1:0]          s_awprot;
    logic [NUM_MASTERS-1:0]            s_awvalid;
    logic [NUM_MASTERS-1:0]            s_awready;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] s_wdata;
    logic [NUM_MASTERS*STRB_WIDTH-1:0] s_wstrb;
    logic [NUM_MASTERS-1:0]            s_wvalid;
    logic [NUM_MASTERS-1:0]            s_wready;
    logic [NUM_MASTERS*2-1:0]          s_bresp;
    logic [NUM_MASTERS-1:0]            s_bvalid;
    logic [NUM_MASTERS-1:0]            s_bready;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_araddr;
    logic [NUM_MASTERS*3-1:0]          s_arprot;
    logic [NUM_MASTERS-1:0]            s_arvalid;
    logic [NUM_MASTERS-1:0]            s_arready;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] s_rdata;
    logic [NUM_MASTERS*2-1:0]          s_rresp;
    logic [NUM_MASTERS-1:0]            s_rvalid;
    logic [NUM_MASTERS-1:0]            s_rready;

    logic [ADDR_WIDTH-1:0] m_awaddr;
    logic [2:0]            m_awprot;
    logic                  m_awvalid;
    logic                  m_awready;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [STRB_WIDTH-1:0] m_wstrb;
    logic                  m_wvalid;
    logic                  m_wready;
    logic [1:0]            m_bresp;
    logic                  m_bvalid;
    logic                  m_bready;
    logic [ADDR_WIDTH-1:0] m_araddr;
    logic [2:0]            m_arprot;
    logic                  m_arvalid;
    logic                  m_arready;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic [1:0]            m_rresp;
    logic                  m_rvalid;
    logic                  m_rready;

    // slave = the arbiter; master = the masters plus interconnect around it
    modport slave (
        input  s_awaddr, s_awprot, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arprot, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid,
        output m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
        output m_araddr, m_arprot, m_arvalid, m_rready,
        input  m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid
    );

    modport master (
        output s_awaddr, s_awprot, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arprot, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid,
        input  m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
        input  m_araddr, m_arprot, m_arvalid, m_rready,
        output m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid
    );
endinterface

// File: rtl/axi_lite_master_arbiter.sv
// rtl/axi_lite_master_arbiter.sv - N-to-1 AXI4-Lite master arbiter with independent write/read grant FSMs
module axi_lite_master_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RR_MODE     = 0,
    localparam int IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        force_en,
    input  logic [IDX_W-1:0]            force_idx,
    axi_lite_master_arbiter_if.slave    bus,
    output logic                        wr_busy,
    output logic                        rd_busy,
    output logic [IDX_W-1:0]            wr_grant,
    output logic [IDX_W-1:0]            rd_grant
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    wr_state_t        wr_state_q, wr_state_d;
    rd_state_t        rd_state_q, rd_state_d;
    logic [IDX_W-1:0] wr_grant_q, wr_grant_d, rd_grant_q, rd_grant_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             aw_done_q, aw_done_d, w_done_q, w_done_d;

    logic [NUM_MASTERS-1:0] force_mask, wr_elig, rd_elig;
    logic [IDX_W-1:0]       wr_win, rd_win;

    // Searches upward from ptr with wrap; fixed priority passes ptr = 0.
    function automatic logic [IDX_W-1:0] pick(input logic [NUM_MASTERS-1:0] req,
                                              input logic [IDX_W-1:0] ptr);
        logic [2*NUM_MASTERS-1:0] dbl;
        logic [NUM_MASTERS-1:0]   rot;
        logic [IDX_W:0]           sum;
        logic [IDX_W-1:0]         win;
        logic                     found;
        dbl   = {req, req};
        rot   = dbl[ptr +: NUM_MASTERS];
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_MASTERS)) sum = sum - (IDX_W+1)'(NUM_MASTERS);
            if (!found && rot[k]) begin
                win   = sum[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] win);
        return (win == IDX_W'(NUM_MASTERS-1)) ? '0 : win + 1'b1;
    endfunction

    always_comb begin
        force_mask = '1;
        if (force_en) begin
            force_mask = '0;
            for (int i = 0; i < NUM_MASTERS; i++)
                if (int'(force_idx) == i) force_mask[i] = 1'b1;
        end
        wr_elig = (bus.s_awvalid | bus.s_wvalid) & force_mask;
        rd_elig = bus.s_arvalid & force_mask;
        wr_win  = pick(wr_elig, (RR_MODE != 0) ? wr_ptr_q : '0);
        rd_win  = pick(rd_elig, (RR_MODE != 0) ? rd_ptr_q : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            wr_grant_q <= '0;
            rd_grant_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_grant_q <= wr_grant_d;
            rd_grant_q <= rd_grant_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    always_comb begin
        wr_state_d    = wr_state_q;
        wr_grant_d    = wr_grant_q;
        wr_ptr_d      = wr_ptr_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        bus.m_awvalid = 1'b0;
        bus.m_wvalid  = 1'b0;
        bus.m_bready  = 1'b0;
        bus.s_awready = '0;
        bus.s_wready  = '0;
        bus.s_bvalid  = '0;
        case (wr_state_q)
            W_IDLE: begin
                if (|wr_elig) begin
                    wr_grant_d = wr_win;
                    wr_ptr_d   = next_ptr(wr_win);
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = W_XFER;
                end
            end
            W_XFER: begin
                bus.m_awvalid             = bus.s_awvalid[wr_grant_q] & ~aw_done_q;
                bus.m_wvalid              = bus.s_wvalid[wr_grant_q] & ~w_done_q;
                bus.s_awready[wr_grant_q] = bus.m_awready & ~aw_done_q;
                bus.s_wready[wr_grant_q]  = bus.m_wready & ~w_done_q;
                aw_done_d = aw_done_q | (bus.s_awvalid[wr_grant_q] & bus.m_awready);
                w_done_d  = w_done_q  | (bus.s_wvalid[wr_grant_q] & bus.m_wready);
                if (aw_done_d && w_done_d) wr_state_d = W_RESP;
            end
            W_RESP: begin
                bus.m_bready             = bus.s_bready[wr_grant_q];
                bus.s_bvalid[wr_grant_q] = bus.m_bvalid;
                if (bus.m_bvalid && bus.s_bready[wr_grant_q]) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d    = rd_state_q;
        rd_grant_d    = rd_grant_q;
        rd_ptr_d      = rd_ptr_q;
        bus.m_arvalid = 1'b0;
        bus.m_rready  = 1'b0;
        bus.s_arready = '0;
        bus.s_rvalid  = '0;
        case (rd_state_q)
            R_IDLE: begin
                if (|rd_elig) begin
                    rd_grant_d = rd_win;
                    rd_ptr_d   = next_ptr(rd_win);
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                bus.m_arvalid             = bus.s_arvalid[rd_grant_q];
                bus.s_arready[rd_grant_q] = bus.m_arready;
                if (bus.s_arvalid[rd_grant_q] && bus.m_arready) rd_state_d = R_DATA;
            end
            R_DATA: begin
                bus.m_rready             = bus.s_rready[rd_grant_q];
                bus.s_rvalid[rd_grant_q] = bus.m_rvalid;
                if (bus.m_rvalid && bus.s_rready[rd_grant_q]) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Payloads follow the grant; response payloads fan out, only the granted valid is raised.
    assign bus.m_awaddr = bus.s_awaddr[wr_grant_q*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.m_awprot = bus.s_awprot[wr_grant_q*3 +: 3];
    assign bus.m_wdata  = bus.s_wdata[wr_grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign bus.m_wstrb  = bus.s_wstrb[wr_grant_q*STRB_WIDTH +: STRB_WIDTH];
    assign bus.m_araddr = bus.s_araddr[rd_grant_q*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.m_arprot = bus.s_arprot[rd_grant_q*3 +: 3];
    assign bus.s_bresp  = {NUM_MASTERS{bus.m_bresp}};
    assign bus.s_rdata  = {NUM_MASTERS{bus.m_rdata}};
    assign bus.s_rresp  = {NUM_MASTERS{bus.m_rresp}};

    assign wr_busy  = (wr_state_q != W_IDLE);
    assign rd_busy  = (rd_state_q != R_IDLE);
    assign wr_grant = wr_grant_q;
    assign rd_grant = rd_grant_q;
endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// tb/tb_axi_lite_master_arbiter.sv - directed self-checking bench for axi_lite_master_arbiter
module tb_axi_lite_master_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_en = 1'b0;
    logic force_idx = 1'b0;
    logic rr_force_en = 1'b0;
    logic rr_force_idx = 1'b0;
    logic fp_wr_busy, fp_rd_busy, rr_wr_busy, rr_rd_busy;
    logic fp_wr_grant, fp_rd_grant, rr_wr_grant, rr_rd_grant;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    axi_lite_master_arbiter_if #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) fi ();
    axi_lite_master_arbiter_if #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ri ();

    axi_lite_master_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .force_en(force_en), .force_idx(force_idx), .bus(fi),
        .wr_busy(fp_wr_busy), .rd_busy(fp_rd_busy), .wr_grant(fp_wr_grant), .rd_grant(fp_rd_grant));

    axi_lite_master_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .force_en(rr_force_en), .force_idx(rr_force_idx), .bus(ri),
        .wr_busy(rr_wr_busy), .rd_busy(rr_rd_busy), .wr_grant(rr_wr_grant), .rd_grant(rr_rd_grant));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fi.s_awaddr = '0; fi.s_awprot = '0; fi.s_awvalid = '0; fi.s_wdata = '0; fi.s_wstrb = '0;
        fi.s_wvalid = '0; fi.s_bready = '0; fi.s_araddr = '0; fi.s_arprot = '0; fi.s_arvalid = '0;
        fi.s_rready = '0; fi.m_awready = 0; fi.m_wready = 0; fi.m_bresp = '0; fi.m_bvalid = 0;
        fi.m_arready = 0; fi.m_rdata = '0; fi.m_rresp = '0; fi.m_rvalid = 0;
        ri.s_awaddr = '0; ri.s_awprot = '0; ri.s_awvalid = '0; ri.s_wdata = '0; ri.s_wstrb = '0;
        ri.s_wvalid = '0; ri.s_bready = '0; ri.s_araddr = '0; ri.s_arprot = '0; ri.s_arvalid = '0;
        ri.s_rready = '0; ri.m_awready = 0; ri.m_wready = 0; ri.m_bresp = '0; ri.m_bvalid = 0;
        ri.m_arready = 0; ri.m_rdata = '0; ri.m_rresp = '0; ri.m_rvalid = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_chk++; if (fp_wr_busy !== 1'b0) begin n_fail++; $display("FAIL rst_wr_busy got=%0b exp=0", fp_wr_busy); end
        n_chk++; if (fp_rd_busy !== 1'b0) begin n_fail++; $display("FAIL rst_rd_busy got=%0b exp=0", fp_rd_busy); end
        n_chk++; if (fp_wr_grant !== 1'b0 || fp_rd_grant !== 1'b0) begin n_fail++; $display("FAIL rst_grants got=%0b/%0b exp=0/0", fp_wr_grant, fp_rd_grant); end
        n_chk++; if ({fi.m_awvalid, fi.m_wvalid, fi.m_bready, fi.m_arvalid, fi.m_rready} !== 5'b0) begin n_fail++; $display("FAIL rst_m_valids got=%05b exp=00000", {fi.m_awvalid, fi.m_wvalid, fi.m_bready, fi.m_arvalid, fi.m_rready}); end
        n_chk++; if ({fi.s_awready, fi.s_wready, fi.s_bvalid, fi.s_arready, fi.s_rvalid} !== 10'b0) begin n_fail++; $display("FAIL rst_s_readies got=%010b exp=0", {fi.s_awready, fi.s_wready, fi.s_bvalid, fi.s_arready, fi.s_rvalid}); end
        n_chk++; if (rr_wr_busy !== 1'b0 || rr_rd_busy !== 1'b0) begin n_fail++; $display("FAIL rst_rr_busy got=%0b/%0b exp=0/0", rr_wr_busy, rr_rd_busy); end
    endtask

    task automatic test_write_m1();
        fi.s_awaddr = {32'h0000_1000, 32'h0};
        fi.s_wdata  = {32'hDEAD_BEEF, 32'h0};
        fi.s_wstrb  = 8'hF0;
        fi.s_awvalid = 2'b10; fi.s_wvalid = 2'b10;
        fi.m_awready = 1'b1;  fi.m_wready = 1'b1;
        #1;
        n_chk++; if (fi.m_awvalid !== 1'b0 || fi.m_wvalid !== 1'b0) begin n_fail++; $display("FAIL wr_idle_no_forward got=%0b%0b exp=00", fi.m_awvalid, fi.m_wvalid); end
        step();
        n_chk++; if (fp_wr_grant !== 1'b1) begin n_fail++; $display("FAIL wr_grant_m1 got=%0b exp=1", fp_wr_grant); end
        n_chk++; if (fi.m_awvalid !== 1'b1 || fi.m_wvalid !== 1'b1) begin n_fail++; $display("FAIL wr_xfer_valids got=%0b%0b exp=11", fi.m_awvalid, fi.m_wvalid); end
        n_chk++; if (fi.m_awaddr !== 32'h0000_1000) begin n_fail++; $display("FAIL wr_awaddr got=%h exp=00001000", fi.m_awaddr); end
        n_chk++; if (fi.m_wdata !== 32'hDEAD_BEEF || fi.m_wstrb !== 4'hF) begin n_fail++; $display("FAIL wr_wdata got=%h/%h exp=deadbeef/f", fi.m_wdata, fi.m_wstrb); end
        n_chk++; if (fi.s_awready !== 2'b10 || fi.s_wready !== 2'b10) begin n_fail++; $display("FAIL wr_s_ready got=%b/%b exp=10/10", fi.s_awready, fi.s_wready); end
        step();
        fi.s_awvalid = 2'b00; fi.s_wvalid = 2'b00; fi.m_awready = 1'b0; fi.m_wready = 1'b0;
        fi.m_bvalid = 1'b1; fi.m_bresp = 2'b00; fi.s_bready = 2'b10;
        #1;
        n_chk++; if (fi.s_bvalid !== 2'b10 || fi.m_bready !== 1'b1) begin n_fail++; $display("FAIL wr_b_route got=%b/%0b exp=10/1", fi.s_bvalid, fi.m_bready); end
        n_chk++; if (fi.s_bresp[3:2] !== 2'b00) begin n_fail++; $display("FAIL wr_bresp_m1 got=%b exp=00", fi.s_bresp[3:2]); end
        step();
        fi.m_bvalid = 1'b0; fi.s_bready = 2'b00;
        #1;
        n_chk++; if (fp_wr_busy !== 1'b0 || fi.s_bvalid !== 2'b00) begin n_fail++; $display("FAIL wr_done_idle got=%0b/%b exp=0/00", fp_wr_busy, fi.s_bvalid); end
        clear_inputs();
    endtask

    task automatic test_read_priority();
        fi.s_araddr = {32'h0000_0200, 32'h0000_0100};
        fi.s_arvalid = 2'b11; fi.m_arready = 1'b1;
        step();
        n_chk++; if (fp_rd_grant !== 1'b0 || fi.m_araddr !== 32'h100) begin n_fail++; $display("FAIL rd_first_m0 got=%0b/%h exp=0/00000100", fp_rd_grant, fi.m_araddr); end
        n_chk++; if (fi.s_arready !== 2'b01) begin n_fail++; $display("FAIL rd_arready_m0 got=%b exp=01", fi.s_arready); end
        step();
        fi.s_arvalid = 2'b10; fi.m_arready = 1'b0;
        fi.m_rvalid = 1'b1; fi.m_rdata = 32'h1234_5678; fi.s_rready = 2'b11;
        #1;
        n_chk++; if (fi.s_rvalid !== 2'b01 || fi.s_rdata[31:0] !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_m0_data got=%b/%h exp=01/12345678", fi.s_rvalid, fi.s_rdata[31:0]); end
        step();
        fi.m_rvalid = 1'b0;
        #1;
        n_chk++; if (fp_rd_busy !== 1'b0) begin n_fail++; $display("FAIL rd_gap_idle got=%0b exp=0", fp_rd_busy); end
        step();
        n_chk++; if (fp_rd_grant !== 1'b1 || fi.m_araddr !== 32'h200 || fi.m_arvalid !== 1'b1) begin n_fail++; $display("FAIL rd_second_m1 got=%0b/%h/%0b exp=1/00000200/1", fp_rd_grant, fi.m_araddr, fi.m_arvalid); end
        fi.m_arready = 1'b1;
        step();
        fi.m_arready = 1'b0; fi.s_arvalid = 2'b00;
        fi.m_rvalid = 1'b1; fi.m_rdata = 32'hCAFE_F00D;
        #1;
        n_chk++; if (fi.s_rvalid !== 2'b10 || fi.s_rdata[63:32] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rd_m1_data got=%b/%h exp=10/cafef00d", fi.s_rvalid, fi.s_rdata[63:32]); end
        step();
        clear_inputs();
    endtask

    task automatic test_w_before_aw();
        fi.s_awaddr = {32'h0000_2000, 32'h0};
        fi.s_wdata  = {32'h5555_AAAA, 32'h0};
        fi.s_awvalid = 2'b10; fi.s_wvalid = 2'b10; fi.s_bready = 2'b10;
        fi.m_wready = 1'b1; fi.m_awready = 1'b0;
        step();
        n_chk++; if (fi.m_wvalid !== 1'b1 || fi.m_awvalid !== 1'b1) begin n_fail++; $display("FAIL split_first got=%0b%0b exp=11", fi.m_awvalid, fi.m_wvalid); end
        step();
        for (int i = 0; i < 2; i++) begin
            n_chk++; if (fi.m_wvalid !== 1'b0 || fi.s_wready !== 2'b00) begin n_fail++; $display("FAIL split_no_dup_w cyc=%0d got=%0b/%b exp=0/00", i, fi.m_wvalid, fi.s_wready); end
            n_chk++; if (fi.m_awvalid !== 1'b1 || fi.m_bready !== 1'b0 || fp_wr_busy !== 1'b1) begin n_fail++; $display("FAIL split_wait_aw cyc=%0d got=%0b/%0b/%0b exp=1/0/1", i, fi.m_awvalid, fi.m_bready, fp_wr_busy); end
            step();
        end
        fi.m_awready = 1'b1;
        #1;
        n_chk++; if (fi.s_awready !== 2'b10 || fi.m_wvalid !== 1'b0) begin n_fail++; $display("FAIL split_aw_hs got=%b/%0b exp=10/0", fi.s_awready, fi.m_wvalid); end
        step();
        fi.m_awready = 1'b0; fi.m_wready = 1'b0;
        fi.m_bresp = 2'b10;
        #1;
        n_chk++; if (fi.m_awvalid !== 1'b0 || fi.m_wvalid !== 1'b0 || fi.m_bready !== 1'b1) begin n_fail++; $display("FAIL split_resp got=%0b%0b/%0b exp=00/1", fi.m_awvalid, fi.m_wvalid, fi.m_bready); end
        fi.s_awvalid = 2'b00; fi.s_wvalid = 2'b00; fi.m_bvalid = 1'b1;
        #1;
        n_chk++; if (fi.s_bvalid !== 2'b10 || fi.s_bresp[3:2] !== 2'b10) begin n_fail++; $display("FAIL split_bresp got=%b/%b exp=10/10", fi.s_bvalid, fi.s_bresp[3:2]); end
        step();
        clear_inputs();
        #1;
        n_chk++; if (fp_wr_busy !== 1'b0) begin n_fail++; $display("FAIL split_back_idle got=%0b exp=0", fp_wr_busy); end
    endtask

    task automatic test_force();
        force_en = 1'b1; force_idx = 1'b0;
        fi.s_awaddr = {32'h0000_00B0, 32'h0000_00A0};
        fi.s_awvalid = 2'b10; fi.s_wvalid = 2'b10;
        fi.m_awready = 1'b1; fi.m_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++; if (fp_wr_busy !== 1'b0 || fi.m_awvalid !== 1'b0) begin n_fail++; $display("FAIL force_block_m1 cyc=%0d got=%0b/%0b exp=0/0", i, fp_wr_busy, fi.m_awvalid); end
            step();
        end
        fi.s_awvalid = 2'b11; fi.s_wvalid = 2'b11;
        step();
        n_chk++; if (fp_wr_grant !== 1'b0 || fi.m_awaddr !== 32'hA0) begin n_fail++; $display("FAIL force_grant_m0 got=%0b/%h exp=0/000000a0", fp_wr_grant, fi.m_awaddr); end
        force_en = 1'b0; force_idx = 1'b1;
        step();
        fi.s_awvalid = 2'b10; fi.s_wvalid = 2'b10; fi.m_awready = 1'b0; fi.m_wready = 1'b0;
        #1;
        n_chk++; if (fp_wr_grant !== 1'b0 || fp_wr_busy !== 1'b1 || fi.s_bvalid !== 2'b00) begin n_fail++; $display("FAIL force_toggle_hold got=%0b/%0b/%b exp=0/1/00", fp_wr_grant, fp_wr_busy, fi.s_bvalid); end
        step();
        fi.m_bvalid = 1'b1; fi.s_bready = 2'b01;
        #1;
        n_chk++; if (fp_wr_grant !== 1'b0 || fi.s_bvalid !== 2'b01) begin n_fail++; $display("FAIL force_b_to_m0 got=%0b/%b exp=0/01", fp_wr_grant, fi.s_bvalid); end
        step();
        fi.m_bvalid = 1'b0; fi.s_bready = 2'b00;
        step();
        n_chk++; if (fp_wr_grant !== 1'b1 || fi.m_awaddr !== 32'hB0) begin n_fail++; $display("FAIL force_release_m1 got=%0b/%h exp=1/000000b0", fp_wr_grant, fi.m_awaddr); end
        fi.m_awready = 1'b1; fi.m_wready = 1'b1;
        step();
        fi.s_awvalid = 2'b00; fi.s_wvalid = 2'b00; fi.m_awready = 1'b0; fi.m_wready = 1'b0;
        fi.m_bvalid = 1'b1; fi.s_bready = 2'b10;
        step();
        clear_inputs();
    endtask

    task automatic test_rr_write();
        int n;
        ri.s_awvalid = 2'b11; ri.s_wvalid = 2'b11; ri.s_bready = 2'b11;
        ri.m_awready = 1'b1; ri.m_wready = 1'b1; ri.m_bvalid = 1'b1;
        #1;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (ri.m_awvalid !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            n_chk++; if (n >= 10) begin n_fail++; $display("FAIL rr_timeout txn=%0d got=no_grant exp=grant", t); end
            n_chk++; if (rr_wr_grant !== t[0]) begin n_fail++; $display("FAIL rr_grant_seq txn=%0d got=%0b exp=%0b", t, rr_wr_grant, t[0]); end
            step();
        end
        ri.s_awvalid = 2'b00; ri.s_wvalid = 2'b00;
        step();
        clear_inputs();
        #1;
        n_chk++; if (rr_wr_busy !== 1'b0) begin n_fail++; $display("FAIL rr_end_idle got=%0b exp=0", rr_wr_busy); end
    endtask

    task automatic test_reset_in_resp();
        fi.s_awvalid = 2'b10; fi.s_wvalid = 2'b10;
        fi.m_awready = 1'b1; fi.m_wready = 1'b1;
        step();
        step();
        fi.s_awvalid = 2'b00; fi.s_wvalid = 2'b00; fi.m_awready = 1'b0; fi.m_wready = 1'b0;
        fi.m_bvalid = 1'b1;
        #1;
        n_chk++; if (fi.s_bvalid !== 2'b10 || fp_wr_busy !== 1'b1) begin n_fail++; $display("FAIL rstresp_pre got=%b/%0b exp=10/1", fi.s_bvalid, fp_wr_busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_chk++; if (fp_wr_busy !== 1'b0 || fp_wr_grant !== 1'b0) begin n_fail++; $display("FAIL rstresp_idle got=%0b/%0b exp=0/0", fp_wr_busy, fp_wr_grant); end
        n_chk++; if ({fi.s_bvalid, fi.m_bready, fi.m_awvalid, fi.m_wvalid, fi.s_awready, fi.s_wready} !== 8'b0) begin n_fail++; $display("FAIL rstresp_quiet got=%08b exp=00000000", {fi.s_bvalid, fi.m_bready, fi.m_awvalid, fi.m_wvalid, fi.s_awready, fi.s_wready}); end
        fi.s_bready = 2'b10;
        step();
        n_chk++; if (fi.s_bvalid !== 2'b00 || fi.m_bready !== 1'b0) begin n_fail++; $display("FAIL rstresp_no_b got=%b/%0b exp=00/0", fi.s_bvalid, fi.m_bready); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_write_m1();
        test_read_priority();
        test_w_before_aw();
        test_force();
        test_rr_write();
        test_reset_in_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
